// File: rtl/bk_pkg.sv
// Shared types for the bkProcessor command generator and result collector.
package bk_pkg;

   localparam int unsigned CMD_W  = 7;
   localparam int unsigned DATA_W = 8;

   // One captured processor result tagged with its originating command
   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              zero;
      logic              error;
   } bk_result_t;

endpackage : bk_pkg

// File: rtl/bk_result_fifo.sv
// First-word-fall-through result FIFO with a registered head and occupancy count.
module bk_result_fifo
   import bk_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  bk_result_t             push_data_i,
   input  logic                   pop_i,
   output bk_result_t             head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   push_acc_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   bk_result_t     mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  rd_nxt;
   logic [CW-1:0]  count_q, count_d;
   bk_result_t     head_q, head_d;
   logic           valid_q, valid_d;
   logic           empty, full, pop_en;

   // Pointer, count and head-register next state; a full FIFO may accept a push only alongside a pop
   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == CW'(DEPTH));
      pop_en     = pop_i & ~empty;
      push_acc_c = push_i & (~full | pop_en);
      rd_nxt     = rd_ptr_q + AW'(1);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;

      if (push_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)     rd_ptr_d = rd_nxt;

      count_d = count_q + CW'(push_acc_c) - CW'(pop_en);

      // Head follows the next stored entry, or the incoming push when nothing else is queued
      if (pop_en && (count_q > CW'(1))) begin
         head_d = mem_q[rd_nxt];
      end else if (push_acc_c && (empty || pop_en)) begin
         head_d = push_data_i;
      end

      valid_d = (count_d != '0);
   end

   // Storage array; contents need no reset
   always_ff @(posedge clk) begin
      if (push_acc_c) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Control and head registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign count_o = count_q;

endmodule : bk_result_fifo

// File: rtl/bk_result_collector.sv
// Tags bkProcessor commands, captures their results after a fixed latency and queues them for a reader.
module bk_result_collector
   import bk_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_issue,
   input  logic [CMD_W-1:0]        cmd_in,
   input  logic [DATA_W-1:0]       dout_low,
   input  logic [DATA_W-1:0]       dout_high,
   input  logic                    zero,
   input  logic                    error,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [CMD_W-1:0]        res_cmd,
   output logic [2*DATA_W-1:0]     res_data,
   output logic                    res_zero,
   output logic                    res_error,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    overflow,
   output logic [CNT_W-1:0]        err_count
);

   logic [LATENCY-1:0]            tag_v_q, tag_v_d;
   logic [LATENCY-1:0][CMD_W-1:0] tag_cmd_q, tag_cmd_d;
   logic                          overflow_q, overflow_d;
   logic [CNT_W-1:0]              err_cnt_q, err_cnt_d;
   logic                          push_req;
   logic                          push_acc;
   bk_result_t                    push_data;
   bk_result_t                    head;

   // Tag pipeline shift: stage 0 samples the issue strobe every cycle
   always_comb begin
      tag_v_d      = tag_v_q;
      tag_cmd_d    = tag_cmd_q;
      tag_v_d[0]   = cmd_issue;
      tag_cmd_d[0] = cmd_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         tag_v_d[i]   = tag_v_q[i-1];
         tag_cmd_d[i] = tag_cmd_q[i-1];
      end
   end

   // Capture request: last tag stage paired with the processor outputs of the same cycle
   always_comb begin
      push_req  = tag_v_q[LATENCY-1];
      push_data = '{cmd:   tag_cmd_q[LATENCY-1],
                    hi:    dout_high,
                    lo:    dout_low,
                    zero:  zero,
                    error: error};
   end

   // Sticky overflow on a dropped capture; saturating count of accepted error results
   always_comb begin
      overflow_d = overflow_q | (push_req & ~push_acc);
      err_cnt_d  = err_cnt_q;
      if (push_acc && push_data.error && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // Tag pipeline and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v_q    <= '0;
         tag_cmd_q  <= '0;
         overflow_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         tag_v_q    <= tag_v_d;
         tag_cmd_q  <= tag_cmd_d;
         overflow_q <= overflow_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   bk_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst),
      .push_i      (push_req),
      .push_data_i (push_data),
      .pop_i       (res_ready),
      .head_o      (head),
      .valid_o     (res_valid),
      .count_o     (fifo_count),
      .push_acc_c  (push_acc)
   );

   assign res_cmd   = head.cmd;
   assign res_data  = {head.hi, head.lo};
   assign res_zero  = head.zero;
   assign res_error = head.error;
   assign overflow  = overflow_q;
   assign err_count = err_cnt_q;

endmodule : bk_result_collector

// File: tb/tb_bk_result_collector.sv
// Bench for bk_result_collector: plays the bkProcessor side and checks the reader side against a queue model.
module tb_bk_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_issue;
   logic [6:0]  cmd_in;
   logic [7:0]  dout_low, dout_high;
   logic        zero, error;
   logic        res_valid, res_ready;
   logic [6:0]  res_cmd;
   logic [15:0] res_data;
   logic        res_zero, res_error;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic [7:0]  err_count;

   bk_result_collector #(.LATENCY(2), .DEPTH(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_issue  (cmd_issue),
      .cmd_in     (cmd_in),
      .dout_low   (dout_low),
      .dout_high  (dout_high),
      .zero       (zero),
      .error      (error),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_cmd    (res_cmd),
      .res_data   (res_data),
      .res_zero   (res_zero),
      .res_error  (res_error),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [6:0] cmd;
      logic [7:0] hi;
      logic [7:0] lo;
      logic       z;
      logic       e;
   } rec_t;

   typedef struct {
      logic        iss;
      logic [6:0]  cmd;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic        z;
      logic        e;
      logic        rdy;
      logic        x_valid;
      logic [3:0]  x_cnt;
      logic [6:0]  x_cmd;
      logic [15:0] x_data;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   delivered = 0;
   rec_t exp_q[$];
   rec_t hist0, hist1, last_head;
   logic m_ovf;
   int   m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      hist0     = '0;
      hist1     = '0;
      last_head = '0;
      m_ovf     = 1'b0;
      m_err     = 0;
   endtask

   // One clock: check current outputs against the model, drive inputs, advance the model and the clock
   task automatic step(input logic iss, input logic [6:0] c, input logic [7:0] h, input logic [7:0] l,
                       input logic z, input logic e, input logic rdy);
      rec_t cap;
      bit   pop, acc;
      if (exp_q.size() != 0) last_head = exp_q[0];
      chk("res_valid",  32'(res_valid),  32'(exp_q.size() != 0));
      chk("res_cmd",    32'(res_cmd),    32'(last_head.cmd));
      chk("res_data",   32'(res_data),   32'({last_head.hi, last_head.lo}));
      chk("res_zero",   32'(res_zero),   32'(last_head.z));
      chk("res_error",  32'(res_error),  32'(last_head.e));
      chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("err_count",  32'(err_count),  32'(m_err));

      cap   = hist1;
      hist1 = hist0;
      hist0 = '{v: iss, cmd: c, hi: h, lo: l, z: z, e: e};

      cmd_issue = iss;
      cmd_in    = c;
      res_ready = rdy;
      if (cap.v) begin
         dout_high = cap.hi;
         dout_low  = cap.lo;
         zero      = cap.z;
         error     = cap.e;
      end else begin
         dout_high = 8'($urandom);
         dout_low  = 8'($urandom);
         zero      = 1'($urandom);
         error     = 1'($urandom);
      end

      pop = rdy && (exp_q.size() > 0);
      acc = cap.v && ((exp_q.size() < 8) || pop);
      if (pop) begin
         void'(exp_q.pop_front());
         delivered++;
      end
      if (acc) begin
         exp_q.push_back(cap);
         if (cap.e && (m_err != 255)) m_err++;
      end else if (cap.v) begin
         m_ovf = 1'b1;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 7'h0, 8'h0, 8'h0, 1'b0, 1'b0, rdy);
   endtask

   // Hold reset for n cycles with inputs toggling; every output must read zero
   task automatic do_reset(input int n);
      rst = 1'b0;
      #1;
      for (int i = 0; i < n; i++) begin
         cmd_issue = 1'($urandom);
         cmd_in    = 7'($urandom);
         dout_high = 8'($urandom);
         dout_low  = 8'($urandom);
         zero      = 1'($urandom);
         error     = 1'($urandom);
         res_ready = 1'($urandom);
         @(posedge clk);
         #1;
         chk("rst_outputs", 32'({res_valid, res_cmd, res_data, res_zero, res_error,
                                 fifo_count, overflow, err_count}), 32'(0));
      end
      model_clear();
      cmd_issue = 1'b0;
      res_ready = 1'b0;
      rst       = 1'b1;
   endtask

   vec_t tbl[5];
   int   d0;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b1, 7'h16, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 7'h00, 16'h0000};
      tbl[1] = '{1'b0, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 7'h00, 16'h0000};
      tbl[2] = '{1'b0, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 7'h16, 16'h1234};
      tbl[3] = '{1'b0, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 7'h16, 16'h1234};
      tbl[4] = '{1'b0, 7'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 7'h16, 16'h1234};

      rst = 1'b1; cmd_issue = 1'b0; cmd_in = '0; res_ready = 1'b0;
      dout_high = '0; dout_low = '0; zero = 1'b0; error = 1'b0;
      model_clear();
      @(posedge clk);
      #1;

      // Reset with toggling inputs, then quiet cycles
      do_reset(5);
      idle(20, 1'b0);

      // Single command, table driven
      for (int i = 0; i < 5; i++) begin
         step(tbl[i].iss, tbl[i].cmd, tbl[i].hi, tbl[i].lo, tbl[i].z, tbl[i].e, tbl[i].rdy);
         chk("tbl_valid", 32'(res_valid),  32'(tbl[i].x_valid));
         chk("tbl_count", 32'(fifo_count), 32'(tbl[i].x_cnt));
         chk("tbl_cmd",   32'(res_cmd),    32'(tbl[i].x_cmd));
         chk("tbl_data",  32'(res_data),   32'(tbl[i].x_data));
      end

      // Burst of 8 fills the FIFO exactly, drains in order
      for (int i = 0; i < 8; i++)
         step(1'b1, 7'(i), 8'(i * 3 + 1), 8'(i * 7 + 2), 1'(i % 4 == 0), 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("burst_count", 32'(fifo_count), 32'd8);
      chk("burst_ovf",   32'(overflow),   32'd0);
      d0 = delivered;
      idle(10, 1'b1);
      chk("burst_delivered", 32'(delivered - d0), 32'd8);

      // Nine issues with no reader: ninth dropped
      for (int i = 0; i < 9; i++)
         step(1'b1, 7'(8'h20 + i), 8'(i + 8'h40), 8'(8'h80 - i), 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      chk("ovf_count", 32'(fifo_count), 32'd8);
      chk("ovf_flag",  32'(overflow),   32'd1);
      d0 = delivered;
      idle(10, 1'b1);
      chk("ovf_delivered", 32'(delivered - d0), 32'd8);
      chk("ovf_sticky",    32'(overflow),       32'd1);

      // Nine issues with a pop on the ninth capture cycle: nothing dropped
      do_reset(2);
      for (int i = 0; i < 9; i++)
         step(1'b1, 7'(8'h30 + i), 8'(i * 5), 8'(i + 1), 1'(i[0]), 1'b0, 1'b0);
      step(1'b0, 7'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
      d0 = delivered;
      step(1'b0, 7'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b1);
      chk("full_pp_count", 32'(fifo_count), 32'd8);
      chk("full_pp_ovf",   32'(overflow),   32'd0);
      idle(10, 1'b1);
      chk("full_pp_delivered", 32'(delivered - d0), 32'd9);

      // Error counting and saturation
      do_reset(2);
      for (int i = 0; i < 5; i++)
         step(1'b1, 7'(8'h50 + i), 8'(i), 8'(i), 1'b0, 1'(i % 2 == 0), 1'b1);
      idle(3, 1'b1);
      chk("err_count3", 32'(err_count), 32'd3);
      for (int i = 0; i < 300; i++)
         step(1'b1, 7'(i), 8'(i), 8'(i >> 8), 1'b0, 1'b1, 1'b1);
      idle(3, 1'b1);
      chk("err_sat", 32'(err_count), 32'd255);
      chk("err_ovf", 32'(overflow),  32'd0);

      // Reset while tags are in flight
      for (int i = 0; i < 3; i++)
         step(1'b1, 7'(8'h60 + i), 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);
      step(1'b0, 7'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0);
      do_reset(2);
      d0 = delivered;
      idle(10, 1'b1);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_valid", 32'(res_valid),  32'd0);
      chk("mid_rst_err",   32'(err_count),  32'd0);
      chk("mid_rst_none",  32'(delivered - d0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bk_result_collector
